// File: rtl/mat_data_mem_banked_pkg.sv
// Shared constants, request opcode and bank-select helper for the banked matrix data memory.
package mat_data_mem_banked_pkg;

   localparam int unsigned MAT_NUM_CH    = 2;
   localparam int unsigned MAT_WIDTH     = 16;
   localparam int unsigned MAT_ELEM_BITS = 32;
   localparam int unsigned MAT_DEPTH     = 2048;
   localparam int unsigned MAT_NUM_BANKS = 4;
   localparam int unsigned MAT_ADDR_SIZE = 32;
   localparam int unsigned MAT_BANK_BITS = $clog2(MAT_NUM_BANKS);

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } mat_mem_op_t;

   // Rows are interleaved: the low address bits select the bank.
   function automatic logic [MAT_BANK_BITS-1:0] bank_of(input logic [MAT_ADDR_SIZE-1:0] addr);
      return MAT_BANK_BITS'(addr);
   endfunction

endpackage

// File: rtl/mat_data_mem_banked_if.sv
// Multi-channel row request / read response bus of the banked matrix data memory.
interface mat_data_mem_banked_if #(
   parameter int unsigned NUM_CH    = mat_data_mem_banked_pkg::MAT_NUM_CH,
   parameter int unsigned WIDTH     = mat_data_mem_banked_pkg::MAT_WIDTH,
   parameter int unsigned ELEM_BITS = mat_data_mem_banked_pkg::MAT_ELEM_BITS,
   parameter int unsigned ADDR_SIZE = mat_data_mem_banked_pkg::MAT_ADDR_SIZE
);
   import mat_data_mem_banked_pkg::*;

   logic        [NUM_CH-1:0]                          req_valid;
   logic        [NUM_CH-1:0]                          req_ready;
   mat_mem_op_t                                       req_op [NUM_CH];
   logic        [NUM_CH-1:0][ADDR_SIZE-1:0]           req_addr;
   logic        [NUM_CH-1:0][WIDTH-1:0]               req_mask;
   logic        [NUM_CH-1:0][WIDTH-1:0][ELEM_BITS-1:0] req_wdata;
   logic        [NUM_CH-1:0]                          rsp_valid;
   logic        [NUM_CH-1:0]                          rsp_err;
   logic        [NUM_CH-1:0][WIDTH-1:0][ELEM_BITS-1:0] rsp_data;

   modport master (
      output req_valid, req_op, req_addr, req_mask, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_mask, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_data
   );

endinterface

// File: rtl/mat_data_mem_banked_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past the winner on advance.
module mat_data_mem_banked_rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt_c
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          found;
   int unsigned   idx;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

   // Scan from the pointer upward with wrap; the first requester wins.
   always_comb begin
      gnt_c = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_q) + k) % N;
         if (!found && req[PW'(idx)]) begin
            found              = 1'b1;
            gnt_c[PW'(idx)]    = 1'b1;
            if (advance) ptr_d = PW'((idx + 1) % N);
         end
      end
   end

endmodule

// File: rtl/mat_data_mem_banked.sv
// Banked multi-channel matrix row memory with per-bank round-robin arbitration and registered reads.
// Optional MAT_DATA_MEM_STATS_EN adds per-channel saturating grant/stall counters.
module mat_data_mem_banked
   import mat_data_mem_banked_pkg::*;
#(
   parameter int unsigned NUM_CH    = MAT_NUM_CH,
   parameter int unsigned WIDTH     = MAT_WIDTH,
   parameter int unsigned ELEM_BITS = MAT_ELEM_BITS,
   parameter int unsigned DEPTH     = MAT_DEPTH,
   parameter int unsigned NUM_BANKS = MAT_NUM_BANKS,
   parameter int unsigned ADDR_SIZE = MAT_ADDR_SIZE
) (
   input  logic                        clock,
   input  logic                        reset_n,
   mat_data_mem_banked_if.slave        bus
`ifdef MAT_DATA_MEM_STATS_EN
   ,
   output logic [NUM_CH-1:0][31:0]     stat_grants,
   output logic [NUM_CH-1:0][31:0]     stat_stalls
`endif
);

   localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
   localparam int unsigned ROWS      = DEPTH / NUM_BANKS;
   localparam int unsigned ROW_BITS  = $clog2(ROWS);

   typedef logic [WIDTH-1:0][ELEM_BITS-1:0] row_t;

   logic [NUM_CH-1:0]    in_range;
   logic [NUM_CH-1:0]    ready;
   logic [NUM_CH-1:0]    rd_fire;
   logic [BANK_BITS-1:0] ch_bank [NUM_CH];
   logic [ROW_BITS-1:0]  ch_row  [NUM_CH];
   logic [NUM_CH-1:0]    bank_gnt [NUM_BANKS];
   row_t                 bank_rdata [NUM_BANKS];

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         ch_bank[c]  = bank_of(bus.req_addr[c]);
         ch_row[c]   = bus.req_addr[c][BANK_BITS +: ROW_BITS];
         in_range[c] = bus.req_addr[c] < ADDR_SIZE'(DEPTH);
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [NUM_CH-1:0] bank_req;
      logic [NUM_CH-1:0] gnt;
      logic              wr_en;
      logic [ROW_BITS-1:0] sel_row;
      logic [WIDTH-1:0]  wr_mask;
      row_t              wr_data;
      row_t              mem [ROWS];

      // Requests are masked in reset so nothing is granted or written.
      always_comb begin
         bank_req = '0;
         for (int unsigned c = 0; c < NUM_CH; c++)
            bank_req[c] = reset_n && bus.req_valid[c] && (ch_bank[c] == BANK_BITS'(b));
      end

      mat_data_mem_banked_rr_arbiter #(.N(NUM_CH)) u_arb (
         .clock   (clock),
         .reset_n (reset_n),
         .req     (bank_req),
         .advance (|bank_req),
         .gnt_c   (gnt)
      );

      always_comb begin
         wr_en   = 1'b0;
         sel_row = '0;
         wr_mask = '0;
         wr_data = '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
               sel_row = ch_row[c];
               wr_en   = (bus.req_op[c] == MEM_WRITE) && in_range[c];
               wr_mask = bus.req_mask[c];
               wr_data = bus.req_wdata[c];
            end
         end
      end

      always_ff @(posedge clock) begin
         if (wr_en) begin
            for (int unsigned e = 0; e < WIDTH; e++)
               if (wr_mask[e]) mem[sel_row][e] <= wr_data[e];
         end
      end

      assign bank_rdata[b] = mem[sel_row];
      assign bank_gnt[b]   = gnt;
   end

   always_comb begin
      ready   = '0;
      rd_fire = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++)
         ready = ready | bank_gnt[b];
      for (int unsigned c = 0; c < NUM_CH; c++)
         rd_fire[c] = ready[c] && (bus.req_op[c] == MEM_READ);
   end

   assign bus.req_ready = ready;

   // Granted reads return the bank row next cycle; out-of-range reads return zero with an error.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp_valid <= '0;
         bus.rsp_err   <= '0;
         bus.rsp_data  <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            bus.rsp_valid[c] <= rd_fire[c];
            bus.rsp_err[c]   <= rd_fire[c] && !in_range[c];
            bus.rsp_data[c]  <= (rd_fire[c] && in_range[c]) ? bank_rdata[ch_bank[c]] : '0;
         end
      end
   end

`ifdef MAT_DATA_MEM_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_grants <= '0;
         stat_stalls <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ready[c] && (stat_grants[c] != '1))
               stat_grants[c] <= stat_grants[c] + 32'd1;
            if (bus.req_valid[c] && !ready[c] && (stat_stalls[c] != '1))
               stat_stalls[c] <= stat_stalls[c] + 32'd1;
         end
      end
   end
`endif

endmodule
